// File: rtl/shift_sub_divider_pkg.sv
// rtl/shift_sub_divider_pkg.sv - shared widths, state encoding and divide-by-zero constants
package shift_sub_divider_pkg;

    localparam int NW    = 8;
    localparam int DW    = 4;
    localparam int CNT_W = 3;

    // counter load value: one step per dividend bit, last step taken at zero
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NW - 1);

    // quotient reported for a zero divisor (all ones, what the algorithm yields anyway)
    localparam logic [NW-1:0] Q_DIVZ = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_sub_divider_div_step.sv
// rtl/shift_sub_divider_div_step.sv - one combinational restoring-division step
module div_step
    import shift_sub_divider_pkg::*;
(
    input  logic [DW:0]   rem,
    input  logic          din,
    input  logic [DW-1:0] d,
    output logic [DW:0]   rem_nxt,
    output logic          qbit
);

    logic [DW+1:0] rem_sh;

    // shift the next dividend bit in; compare/subtract against the zero-extended divisor
    always_comb begin
        rem_sh  = {rem, din};
        qbit    = (rem_sh >= {2'b00, d});
        rem_nxt = qbit ? (rem_sh[DW:0] - {1'b0, d}) : rem_sh[DW:0];
    end

endmodule

// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - 8/4-bit shift-subtract divider; DIVZ_DETECT_EN enables divide-by-zero shortcut
module shift_sub_divider
    import shift_sub_divider_pkg::*;
(
    input  logic          CK,
    input  logic          RN,
    input  logic          START,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    output logic [NW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          READY,
    output logic          DIVZ
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DW:0]      rem;
    logic [NW-1:0]    dvd;
    logic [NW-1:0]    qacc;
    logic [DW-1:0]    dreg;
    logic             divz_pend;
    logic [DW:0]      rem_nxt;
    logic             qbit;
    logic             d_zero;

`ifdef DIVZ_DETECT_EN
    assign d_zero = (D == '0);
`else
    assign d_zero = 1'b0;
`endif

    assign READY = (state == IDLE);

    div_step u_step (
        .rem     (rem),
        .din     (dvd[NW-1]),
        .d       (dreg),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // state register
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state: START only looked at in IDLE; last step (or zero-divisor shortcut) returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = RUN;
            RUN:     if (divz_pend || (cnt == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: capture in IDLE, one restoring step per RUN edge, publish results only on completion
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            qacc      <= '0;
            dreg      <= '0;
            divz_pend <= 1'b0;
            Q         <= '0;
            R         <= '0;
            DIVZ      <= 1'b0;
        end else if (state == IDLE) begin
            if (START) begin
                dvd       <= N;
                dreg      <= D;
                rem       <= '0;
                qacc      <= '0;
                cnt       <= d_zero ? '0 : CNT_INIT;
                divz_pend <= d_zero;
            end
        end else if (divz_pend) begin
            divz_pend <= 1'b0;
            Q         <= Q_DIVZ;
            R         <= dvd[DW-1:0];
            DIVZ      <= 1'b1;
        end else begin
            rem  <= rem_nxt;
            dvd  <= {dvd[NW-2:0], 1'b0};
            qacc <= {qacc[NW-2:0], qbit};
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                Q    <= {qacc[NW-2:0], qbit};
                R    <= rem_nxt[DW-1:0];
                DIVZ <= 1'b0;
            end
        end
    end

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 The module SHALL have these ports:
- CK, input, 1: single clock; all state updates on the rising edge.
- RN, input, 1: reset, asynchronous, active-low.
- START, input, 1: request to begin a division.
- N, input, 8: unsigned dividend.
- D, input, 4: unsigned divisor.
- Q, output, 8: unsigned quotient.
- R, output, 4: unsigned remainder.
- READY, output, 1: idle; Q and R are valid.
- DIVZ, output, 1: the last accepted operation had D=0.

REQ-002 The module SHALL have one clock domain (CK) and one reset (RN), asynchronous and active-low.

Function
REQ-003 The FSM SHALL have the states IDLE and RUN, with IDLE=0 and RUN=1, and READY = (state==IDLE).
REQ-004 In IDLE, START=1 at edge k SHALL capture N and D, clear the partial remainder (5 bits) and the quotient register, load the 3-bit counter with 7, and enter RUN.
REQ-005 Each RUN edge SHALL perform one restoring step:
- rem' = {rem[3:0], dividend MSB}; dividend shifted left by 1.
- If rem' >= {0,D}: rem = rem' - D and shift quotient bit 1.
- Otherwise: rem = rem' and shift quotient bit 0.
REQ-006 The counter SHALL decrement once per RUN edge; the step taken with counter==0 SHALL return the FSM to IDLE.
REQ-007 Latency SHALL be exactly 8 RUN edges (k+1..k+8): READY=0 after edge k and READY=1 after edge k+8, with Q and R final.
REQ-008 Q and R SHALL update only on the completing edge and SHALL hold their values in IDLE until the next completion.
REQ-009 START during RUN SHALL be ignored, with no restart and no queuing; START held high in IDLE SHALL restart on every IDLE edge.
REQ-010 Changes on N and D after the capture edge SHALL NOT affect the result.
REQ-011 Results SHALL satisfy N = Q*D + R with R < D for every D != 0.
REQ-012 For D=0, the result SHALL be Q=8'hFF and R=N[3:0], which is the natural result of the algorithm.
REQ-013 DIVZ SHALL update at the same edge as Q and R.

Reset
REQ-014 While RN=0, the outputs SHALL be: state=IDLE, READY=1, Q=0, R=0, DIVZ=0, counter=0, and internal registers=0.
REQ-015 Asserting RN mid-RUN SHALL abort the operation immediately, with no partial result retained.
REQ-016 The first START after deassertion SHALL be honoured at the first rising CK edge where RN=1.

Configuration
REQ-017 The macro DIVZ_DETECT_EN SHALL control divide-by-zero detection.
- Defined: D=0 at capture skips RUN and completes at edge k+1 with READY=1, Q=8'hFF, R=N[3:0], DIVZ=1. Any D != 0 sets DIVZ=0.
- Undefined: DIVZ is tied to 0, and D=0 runs the full 8 steps with the REQ-012 result.

Structure
REQ-018 A shared package SHALL hold:
- NW=8, DW=4, CNT_W=3.
- The state enum (IDLE, RUN).
- The DIVZ result constants (Q_DIVZ=8'hFF).
REQ-019 The one sub-module SHALL be div_step, a combinational restoring step:
- Inputs: rem (5 bits), next dividend bit, D.
- Outputs: new rem and the quotient bit.
- shift_sub_divider instantiates it once.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- N=200, D=7, START pulse -> READY low 8 cycles, then Q=8'h1C (28), R=4, DIVZ=0.
- N=255, D=1 -> Q=8'hFF, R=0. N=0, D=5 -> Q=0, R=0. N=15, D=15 -> Q=1, R=0.
- START pulsed at RUN cycles 2 and 5 with different N/D -> first result unchanged; completion still at edge k+8.
- N=8'h3A, D=0 -> Q=8'hFF, R=4'hA.
  - With DIVZ_DETECT_EN: DIVZ=1 and READY after 1 cycle.
  - Without: DIVZ=0 and READY after 8 cycles.
- RN pulsed low at RUN cycle 4 -> READY=1, Q=0, R=0 immediately; a new START N=100, D=9 -> Q=11, R=1.
- START held high across 3 operations with N=50, D=6 -> back-to-back results Q=8, R=2, each returning to IDLE for exactly one cycle.
